// File: rtl/axi_arbiter.sv
// Two-master AXI4-Lite arbiter: IFU (read-only) and LSU (read/write) share one slave port.
// One transaction in flight at a time; responses are routed only to the granted master.
module axi_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit LSU_FIRST = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  // IFU read channels
  input  logic                ifu_arvalid_i,
  input  logic [ADDR_W-1:0]   ifu_araddr_i,
  output logic                ifu_arready_o,
  output logic                ifu_rvalid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  input  logic                ifu_rready_i,
  // LSU read channels
  input  logic                lsu_arvalid_i,
  input  logic [ADDR_W-1:0]   lsu_araddr_i,
  input  logic [2:0]          lsu_arsize_i,
  output logic                lsu_arready_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  input  logic                lsu_rready_i,
  // LSU write channels
  input  logic                lsu_awvalid_i,
  input  logic [ADDR_W-1:0]   lsu_awaddr_i,
  output logic                lsu_awready_o,
  input  logic                lsu_wvalid_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wstrb_i,
  output logic                lsu_wready_o,
  output logic                lsu_bvalid_o,
  output logic [1:0]          lsu_bresp_o,
  input  logic                lsu_bready_i,
  // Slave port
  output logic                arvalid_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic [2:0]          arsize_o,
  input  logic                arready_i,
  input  logic                rvalid_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic                rready_o,
  output logic                awvalid_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  input  logic                awready_i,
  output logic                wvalid_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic                wready_i,
  input  logic                bvalid_i,
  input  logic [1:0]          bresp_i,
  output logic                bready_o,
  // Grant state: 0 IDLE, 1 IFU_RD, 2 LSU_RD, 3 LSU_WR
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFU_RD = 2'd1,
    ST_LSU_RD = 2'd2,
    ST_LSU_WR = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_ar_done;
  logic   r_aw_done;
  logic   r_w_done;
  logic   w_wr_req;
  logic   w_ar_hs;
  logic   w_aw_hs;
  logic   w_w_hs;
  logic   w_b_gate;

  // Handshake rule on every channel: a transfer happens on a rising edge
  // where valid and ready are both high; valid and payload are held until then.
  assign w_wr_req    = lsu_awvalid_i | lsu_wvalid_i;
  assign dbg_state_o = r_state;

  always_comb begin
    w_next        = r_state;
    w_ar_hs       = 1'b0;
    w_aw_hs       = 1'b0;
    w_w_hs        = 1'b0;
    w_b_gate      = 1'b0;
    ifu_arready_o = 1'b0;
    ifu_rvalid_o  = 1'b0;
    ifu_rdata_o   = '0;
    lsu_arready_o = 1'b0;
    lsu_rvalid_o  = 1'b0;
    lsu_rdata_o   = '0;
    lsu_awready_o = 1'b0;
    lsu_wready_o  = 1'b0;
    lsu_bvalid_o  = 1'b0;
    lsu_bresp_o   = 2'b00;
    arvalid_o     = 1'b0;
    araddr_o      = '0;
    arsize_o      = 3'b000;
    rready_o      = 1'b0;
    awvalid_o     = 1'b0;
    awaddr_o      = '0;
    wvalid_o      = 1'b0;
    wdata_o       = '0;
    wstrb_o       = '0;
    bready_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (LSU_FIRST) begin
          if (w_wr_req)           w_next = ST_LSU_WR;
          else if (lsu_arvalid_i) w_next = ST_LSU_RD;
          else if (ifu_arvalid_i) w_next = ST_IFU_RD;
        end else begin
          if (ifu_arvalid_i)      w_next = ST_IFU_RD;
          else if (w_wr_req)      w_next = ST_LSU_WR;
          else if (lsu_arvalid_i) w_next = ST_LSU_RD;
        end
      end
      ST_IFU_RD: begin
        arvalid_o     = ifu_arvalid_i & ~r_ar_done;
        araddr_o      = ifu_araddr_i;
        arsize_o      = 3'b010;
        ifu_arready_o = arready_i & ~r_ar_done;
        w_ar_hs       = arvalid_o & arready_i;
        rready_o      = ifu_rready_i;
        ifu_rvalid_o  = rvalid_i;
        ifu_rdata_o   = rdata_i;
        if (rvalid_i & ifu_rready_i) w_next = ST_IDLE;
      end
      ST_LSU_RD: begin
        arvalid_o     = lsu_arvalid_i & ~r_ar_done;
        araddr_o      = lsu_araddr_i;
        arsize_o      = lsu_arsize_i;
        lsu_arready_o = arready_i & ~r_ar_done;
        w_ar_hs       = arvalid_o & arready_i;
        rready_o      = lsu_rready_i;
        lsu_rvalid_o  = rvalid_i;
        lsu_rdata_o   = rdata_i;
        if (rvalid_i & lsu_rready_i) w_next = ST_IDLE;
      end
      ST_LSU_WR: begin
        awvalid_o     = lsu_awvalid_i & ~r_aw_done;
        awaddr_o      = lsu_awaddr_i;
        lsu_awready_o = awready_i & ~r_aw_done;
        w_aw_hs       = awvalid_o & awready_i;
        wvalid_o      = lsu_wvalid_i & ~r_w_done;
        wdata_o       = lsu_wdata_i;
        wstrb_o       = lsu_wstrb_i;
        lsu_wready_o  = wready_i & ~r_w_done;
        w_w_hs        = wvalid_o & wready_i;
        // The response is only exposed once both AW and W are (being) accepted.
        w_b_gate      = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
        bready_o      = lsu_bready_i & w_b_gate;
        lsu_bvalid_o  = bvalid_i & w_b_gate;
        lsu_bresp_o   = bresp_i;
        if (bvalid_i & bready_o) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_IDLE) begin
        r_ar_done <= 1'b0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_ar_hs) r_ar_done <= 1'b1;
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Bench for axi_arbiter: directed scenarios followed by randomized traffic checked
// against a transaction-level scoreboard of masters and a slave model.
module tb_axi_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IFU_RD = 2'd1;
  localparam logic [1:0] ST_LSU_RD = 2'd2;
  localparam logic [1:0] ST_LSU_WR = 2'd3;

  logic          clock, reset;
  logic          ifu_arvalid_i, ifu_arready_o, ifu_rvalid_o, ifu_rready_i;
  logic [AW-1:0] ifu_araddr_i;
  logic [DW-1:0] ifu_rdata_o;
  logic          lsu_arvalid_i, lsu_arready_o, lsu_rvalid_o, lsu_rready_i;
  logic [AW-1:0] lsu_araddr_i;
  logic [2:0]    lsu_arsize_i;
  logic [DW-1:0] lsu_rdata_o;
  logic          lsu_awvalid_i, lsu_awready_o, lsu_wvalid_i, lsu_wready_o;
  logic [AW-1:0] lsu_awaddr_i;
  logic [DW-1:0] lsu_wdata_i;
  logic [3:0]    lsu_wstrb_i;
  logic          lsu_bvalid_o, lsu_bready_i;
  logic [1:0]    lsu_bresp_o;
  logic          arvalid_o, arready_i, rvalid_i, rready_o;
  logic [AW-1:0] araddr_o;
  logic [2:0]    arsize_o;
  logic [DW-1:0] rdata_i;
  logic          awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
  logic [AW-1:0] awaddr_o;
  logic [DW-1:0] wdata_o;
  logic [3:0]    wstrb_o;
  logic [1:0]    bresp_i;
  logic [1:0]    dbg_state_o;

  axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LSU_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid_i(ifu_arvalid_i), .ifu_araddr_i(ifu_araddr_i), .ifu_arready_o(ifu_arready_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o), .ifu_rready_i(ifu_rready_i),
    .lsu_arvalid_i(lsu_arvalid_i), .lsu_araddr_i(lsu_araddr_i), .lsu_arsize_i(lsu_arsize_i),
    .lsu_arready_o(lsu_arready_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_rready_i(lsu_rready_i),
    .lsu_awvalid_i(lsu_awvalid_i), .lsu_awaddr_i(lsu_awaddr_i), .lsu_awready_o(lsu_awready_o),
    .lsu_wvalid_i(lsu_wvalid_i), .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i),
    .lsu_wready_o(lsu_wready_o), .lsu_bvalid_o(lsu_bvalid_o), .lsu_bresp_o(lsu_bresp_o),
    .lsu_bready_i(lsu_bready_i),
    .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arsize_o(arsize_o), .arready_i(arready_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rready_o(rready_o),
    .awvalid_o(awvalid_o), .awaddr_o(awaddr_o), .awready_i(awready_i),
    .wvalid_o(wvalid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wready_i(wready_i),
    .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [11:0] vr();
    return {ifu_arready_o, ifu_rvalid_o, lsu_arready_o, lsu_rvalid_o, lsu_awready_o,
            lsu_wready_o, lsu_bvalid_o, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o};
  endfunction

  task automatic clr_inputs();
    ifu_arvalid_i = 0; ifu_araddr_i = '0; ifu_rready_i = 0;
    lsu_arvalid_i = 0; lsu_araddr_i = '0; lsu_arsize_i = '0; lsu_rready_i = 0;
    lsu_awvalid_i = 0; lsu_awaddr_i = '0; lsu_wvalid_i = 0; lsu_wdata_i = '0;
    lsu_wstrb_i = '0; lsu_bready_i = 0;
    arready_i = 0; rvalid_i = 0; rdata_i = '0; awready_i = 0; wready_i = 0;
    bvalid_i = 0; bresp_i = '0;
  endtask

  // ---------------- scoreboard / reference model state ----------------
  logic [DW-1:0] ifu_exp_q[$];
  logic [DW-1:0] lsu_exp_q[$];
  logic [1:0]    b_exp_q[$];
  logic [DW-1:0] s_rd_q[$];
  logic [1:0]    s_b_q[$];
  int  ifu_st, lsu_st;        // ifu: 0 idle,1 addr,2 data; lsu: 0 idle,1 raddr,2 rdata,3 waddr/wdata,4 bresp
  bit  aw_pend, w_pend, s_aw_seen, s_w_seen, s_rv, s_bv;
  bit  f_ar, f_r, f_aw, f_w, f_b, is_ifu_ar;
  bit  m_ifu_ar, m_lsu_ar, m_ifu_r, m_lsu_r, m_aw, m_w, m_b;
  int  n_ifu_done, n_lsu_rd, n_lsu_wr;
  logic [1:0] rsp;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return a ^ 32'h5a5a_a5a5;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    clr_inputs();
    reset = 1'b1;
    tick();
    chk("reset_state", dbg_state_o, ST_IDLE);
    chk("reset_outputs", vr(), 12'h000);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_outputs", vr(), 12'h000);

    // IFU read, slave ready immediately, data two cycles after the AR handshake
    ifu_arvalid_i = 1; ifu_araddr_i = 32'h8000_0000; ifu_rready_i = 1; arready_i = 1;
    #1;
    chk("ifu_lat_idle_arvalid", arvalid_o, 0);
    tick();
    chk("ifu_grant_arvalid", arvalid_o, 1);
    chk("ifu_grant_araddr", araddr_o, 32'h8000_0000);
    chk("ifu_grant_arsize", arsize_o, 3'b010);
    chk("ifu_grant_arready", ifu_arready_o, 1);
    tick();
    ifu_arvalid_i = 0; arready_i = 0;
    #1;
    chk("ifu_ar_done_arvalid", arvalid_o, 0);
    tick();
    rvalid_i = 1; rdata_i = 32'h0000_0413;
    #1;
    chk("ifu_rvalid", ifu_rvalid_o, 1);
    chk("ifu_rdata", ifu_rdata_o, 32'h0000_0413);
    chk("ifu_rready_o", rready_o, 1);
    chk("ifu_lsu_rvalid_quiet", lsu_rvalid_o, 0);
    tick();
    rvalid_i = 0;
    #1;
    chk("ifu_back_idle", dbg_state_o, ST_IDLE);
    chk("ifu_back_idle_out", vr(), 12'h000);

    // Simultaneous IFU and LSU reads: LSU first, IFU one cycle after LSU completion
    ifu_arvalid_i = 1; ifu_araddr_i = 32'h8000_0100;
    lsu_arvalid_i = 1; lsu_araddr_i = 32'h8000_0200; lsu_arsize_i = 3'b000;
    lsu_rready_i = 1; ifu_rready_i = 1;
    tick();
    chk("prio_state", dbg_state_o, ST_LSU_RD);
    chk("prio_araddr", araddr_o, 32'h8000_0200);
    chk("prio_arsize", arsize_o, 3'b000);
    chk("prio_ifu_arready", ifu_arready_o, 0);
    arready_i = 1;
    #1;
    chk("prio_lsu_arready", lsu_arready_o, 1);
    tick();
    lsu_arvalid_i = 0; arready_i = 0; rvalid_i = 1; rdata_i = 32'h0000_0055;
    #1;
    chk("prio_lsu_rdata", lsu_rdata_o, 32'h0000_0055);
    chk("prio_ifu_rvalid_quiet", ifu_rvalid_o, 0);
    tick();
    rvalid_i = 0;
    #1;
    chk("prio_gap_idle", dbg_state_o, ST_IDLE);
    chk("prio_gap_arvalid", arvalid_o, 0);
    tick();
    chk("prio_ifu_state", dbg_state_o, ST_IFU_RD);
    chk("prio_ifu_araddr", araddr_o, 32'h8000_0100);
    arready_i = 1;
    tick();
    ifu_arvalid_i = 0; arready_i = 0; rvalid_i = 1; rdata_i = 32'h0000_0077;
    #1;
    chk("prio_ifu_rdata", ifu_rdata_o, 32'h0000_0077);
    tick();
    rvalid_i = 0; ifu_rready_i = 0; lsu_rready_i = 0;

    // LSU write: awready in cycle 1, wready in cycle 3
    lsu_awvalid_i = 1; lsu_awaddr_i = 32'h8000_0004;
    lsu_wvalid_i = 1; lsu_wdata_i = 32'h0000_AB00; lsu_wstrb_i = 4'b0010; lsu_bready_i = 1;
    tick();
    awready_i = 1;
    #1;
    chk("wr_state", dbg_state_o, ST_LSU_WR);
    chk("wr_c1_valids", {awvalid_o, wvalid_o}, 2'b11);
    chk("wr_awaddr", awaddr_o, 32'h8000_0004);
    chk("wr_wdata", wdata_o, 32'h0000_AB00);
    chk("wr_wstrb", wstrb_o, 4'b0010);
    chk("wr_awready", lsu_awready_o, 1);
    tick();
    lsu_awvalid_i = 0; awready_i = 0;
    #1;
    chk("wr_c2_valids", {awvalid_o, wvalid_o, bready_o}, 3'b010);
    tick();
    wready_i = 1;
    #1;
    chk("wr_c3_wvalid", wvalid_o, 1);
    chk("wr_c3_wready", lsu_wready_o, 1);
    tick();
    lsu_wvalid_i = 0; wready_i = 0; bvalid_i = 1; bresp_i = 2'b00;
    #1;
    chk("wr_b", {lsu_bvalid_o, bready_o, wvalid_o}, 3'b110);
    chk("wr_bresp", lsu_bresp_o, 2'b00);
    tick();
    bvalid_i = 0; lsu_bready_i = 0;
    #1;
    chk("wr_back_idle", dbg_state_o, ST_IDLE);

    // AR stall: slave holds arready low for 5 cycles
    ifu_arvalid_i = 1; ifu_araddr_i = 32'h8000_0010; ifu_rready_i = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_pkt", {dbg_state_o, arvalid_o, ifu_arready_o, araddr_o},
          {ST_IFU_RD, 1'b1, 1'b0, 32'h8000_0010});
      tick();
    end
    arready_i = 1;
    tick();
    ifu_arvalid_i = 0; arready_i = 0; rvalid_i = 1; rdata_i = 32'h1234_5678;
    #1;
    chk("stall_rdata", ifu_rdata_o, 32'h1234_5678);
    tick();
    rvalid_i = 0; ifu_rready_i = 0;
    #1;

    // Spurious responses while idle
    rvalid_i = 1; bvalid_i = 1; ifu_rready_i = 1; lsu_rready_i = 1; lsu_bready_i = 1;
    #1;
    chk("spur_rready", rready_o, 0);
    chk("spur_rvalid", {ifu_rvalid_o, lsu_rvalid_o, lsu_bvalid_o, bready_o}, 4'b0000);
    tick();
    chk("spur_idle", dbg_state_o, ST_IDLE);
    clr_inputs();

    // Reset in LSU_WR after the AW handshake, before W
    lsu_awvalid_i = 1; lsu_awaddr_i = 32'h8000_0008; lsu_wvalid_i = 1;
    lsu_wdata_i = 32'hCAFE_0000; lsu_wstrb_i = 4'hF; awready_i = 1;
    tick();
    tick();
    lsu_awvalid_i = 0; awready_i = 0;
    #1;
    chk("rst_pre_state", {dbg_state_o, awvalid_o, wvalid_o}, {ST_LSU_WR, 1'b0, 1'b1});
    reset = 1; lsu_wvalid_i = 0;
    tick();
    chk("rst_mid_state", dbg_state_o, ST_IDLE);
    chk("rst_mid_out", vr(), 12'h000);
    reset = 0;
    lsu_awvalid_i = 1; lsu_wvalid_i = 1; lsu_bready_i = 1;
    tick();
    chk("rst_aw_cleared", {awvalid_o, wvalid_o}, 2'b11);
    awready_i = 1; wready_i = 1;
    tick();
    clr_inputs();
    lsu_bready_i = 1; bvalid_i = 1; bresp_i = 2'b01;
    #1;
    chk("rst_after_bresp", {lsu_bvalid_o, lsu_bresp_o}, {1'b1, 2'b01});
    tick();
    clr_inputs();
    tick();

    // ---------------- randomized traffic ----------------
    ifu_st = 0; lsu_st = 0; aw_pend = 0; w_pend = 0;
    s_aw_seen = 0; s_w_seen = 0; s_rv = 0; s_bv = 0;
    n_ifu_done = 0; n_lsu_rd = 0; n_lsu_wr = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      // masters
      if (ifu_st == 0 && cyc < 3000 && $urandom_range(0, 2) == 0) begin
        ifu_st = 1; ifu_arvalid_i = 1;
        ifu_araddr_i = 32'h8000_0000 | ($urandom() & 32'h0fff_fffc);
      end
      if (lsu_st == 0 && cyc < 3000 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          lsu_st = 1; lsu_arvalid_i = 1;
          lsu_araddr_i = 32'h9000_0000 | ($urandom() & 32'h0fff_ffff);
          lsu_arsize_i = 3'($urandom_range(0, 2));
        end else begin
          lsu_st = 3; aw_pend = 1; w_pend = 1;
          lsu_awaddr_i = 32'h9000_0000 | ($urandom() & 32'h0fff_ffff);
          lsu_wdata_i = $urandom();
          lsu_wstrb_i = 4'($urandom_range(1, 15));
        end
      end
      if (aw_pend && !lsu_awvalid_i && $urandom_range(0, 1) == 1) lsu_awvalid_i = 1;
      if (w_pend && !lsu_wvalid_i && $urandom_range(0, 1) == 1) lsu_wvalid_i = 1;
      ifu_rready_i = 1'($urandom_range(0, 1));
      lsu_rready_i = 1'($urandom_range(0, 1));
      lsu_bready_i = 1'($urandom_range(0, 1));
      // slave
      arready_i = 1'($urandom_range(0, 1));
      awready_i = 1'($urandom_range(0, 1));
      wready_i  = 1'($urandom_range(0, 1));
      if (!s_rv && s_rd_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        s_rv = 1; rdata_i = s_rd_q[0];
      end
      if (!s_bv && s_b_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        s_bv = 1; bresp_i = s_b_q[0];
      end
      rvalid_i = s_rv;
      bvalid_i = s_bv;
      #1;
      // observe handshakes that will occur on the coming edge
      f_ar = arvalid_o & arready_i;   f_r = rvalid_i & rready_o;
      f_aw = awvalid_o & awready_i;   f_w = wvalid_o & wready_i;
      f_b  = bvalid_i & bready_o;
      m_ifu_ar = ifu_arvalid_i & ifu_arready_o;  m_lsu_ar = lsu_arvalid_i & lsu_arready_o;
      m_ifu_r  = ifu_rvalid_o & ifu_rready_i;    m_lsu_r  = lsu_rvalid_o & lsu_rready_i;
      m_aw = lsu_awvalid_i & lsu_awready_o;      m_w = lsu_wvalid_i & lsu_wready_o;
      m_b  = lsu_bvalid_o & lsu_bready_i;
      is_ifu_ar = (araddr_o[31:28] == 4'h8);
      chk("rnd_ifu_ar_hs", m_ifu_ar, f_ar & is_ifu_ar);
      chk("rnd_lsu_ar_hs", m_lsu_ar, f_ar & !is_ifu_ar);
      if (f_ar) begin
        if (is_ifu_ar) begin
          chk("rnd_ifu_ar_pkt", {arsize_o, araddr_o}, {3'b010, ifu_araddr_i});
          ifu_exp_q.push_back(mem_data(araddr_o));
        end else begin
          chk("rnd_lsu_ar_pkt", {arsize_o, araddr_o}, {lsu_arsize_i, lsu_araddr_i});
          lsu_exp_q.push_back(mem_data(araddr_o));
        end
        s_rd_q.push_back(mem_data(araddr_o));
      end
      chk("rnd_r_route", m_ifu_r | m_lsu_r, f_r);
      chk("rnd_r_excl", ifu_rvalid_o & lsu_rvalid_o, 0);
      if (m_ifu_r) begin
        if (ifu_exp_q.size() == 0) chk("rnd_ifu_r_extra", 1, 0);
        else chk("rnd_ifu_rdata", ifu_rdata_o, ifu_exp_q.pop_front());
      end
      if (m_lsu_r) begin
        if (lsu_exp_q.size() == 0) chk("rnd_lsu_r_extra", 1, 0);
        else chk("rnd_lsu_rdata", lsu_rdata_o, lsu_exp_q.pop_front());
      end
      chk("rnd_aw_hs", m_aw, f_aw);
      chk("rnd_w_hs", m_w, f_w);
      if (f_aw) begin
        chk("rnd_awaddr", awaddr_o, lsu_awaddr_i);
        s_aw_seen = 1;
      end
      if (f_w) begin
        chk("rnd_wpkt", {wstrb_o, wdata_o}, {lsu_wstrb_i, lsu_wdata_i});
        s_w_seen = 1;
      end
      if (s_aw_seen && s_w_seen) begin
        rsp = 2'($urandom_range(0, 3));
        s_b_q.push_back(rsp); b_exp_q.push_back(rsp);
        s_aw_seen = 0; s_w_seen = 0;
      end
      chk("rnd_b_hs", m_b, f_b);
      if (m_b) begin
        if (b_exp_q.size() == 0) chk("rnd_b_extra", 1, 0);
        else chk("rnd_bresp", lsu_bresp_o, b_exp_q.pop_front());
      end
      tick();
      // apply handshake consequences
      if (m_ifu_ar) begin ifu_arvalid_i = 0; ifu_st = 2; end
      if (m_ifu_r)  begin ifu_st = 0; n_ifu_done++; end
      if (m_lsu_ar) begin lsu_arvalid_i = 0; lsu_st = 2; end
      if (m_lsu_r)  begin lsu_st = 0; n_lsu_rd++; end
      if (m_aw) begin lsu_awvalid_i = 0; aw_pend = 0; end
      if (m_w)  begin lsu_wvalid_i = 0; w_pend = 0; end
      if (lsu_st == 3 && !aw_pend && !w_pend) lsu_st = 4;
      if (m_b)  begin lsu_st = 0; n_lsu_wr++; end
      if (f_r) begin s_rv = 0; if (s_rd_q.size() > 0) void'(s_rd_q.pop_front()); end
      if (f_b) begin s_bv = 0; if (s_b_q.size() > 0) void'(s_b_q.pop_front()); end
    end
    chk("rnd_drained_masters", {ifu_st[3:0], lsu_st[3:0]}, 8'h00);
    chk("rnd_drained_queues",
        ifu_exp_q.size() + lsu_exp_q.size() + b_exp_q.size() + s_rd_q.size() + s_b_q.size(), 0);
    chk("rnd_ifu_progress", n_ifu_done > 0, 1);
    chk("rnd_lsu_rd_progress", n_lsu_rd > 0, 1);
    chk("rnd_lsu_wr_progress", n_lsu_wr > 0, 1);
    chk("rnd_final_idle", dbg_state_o, ST_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
